// File: rtl/edge_debounce.sv
// Multi-channel synchroniser, debouncer and edge-pulse generator.
// Define EDGE_DEBOUNCE_STICKY_EN to build the sticky pend register.
module edge_debounce #(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 0,
    parameter int MODE        = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic [WIDTH-1:0] clr,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] evt,
    output logic [WIDTH-1:0] pend
);

    localparam int CW = (DEBOUNCE == 0) ? 1 : $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] DMAX = CW'(DEBOUNCE);

    logic [WIDTH-1:0]         s;
    logic [WIDTH-1:0]         level_q, level_d;
    logic [WIDTH-1:0]         rise_q, rise_d;
    logic [WIDTH-1:0]         fall_q, fall_d;
    logic [WIDTH-1:0]         evt_q, evt_d;
    logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = in;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= in;
                    for (int k = 1; k < SYNC_STAGES; k++) begin
                        sync_q[k] <= sync_q[k-1];
                    end
                end
            end

            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // A change is accepted only once it has persisted DEBOUNCE extra cycles.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (s[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] != DMAX) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end else begin
                cnt_d[i]   = '0;
                level_d[i] = s[i];
                rise_d[i]  = s[i];
                fall_d[i]  = ~s[i];
            end
        end
    end

    always_comb begin
        if (MODE == 0) begin
            evt_d = rise_d;
        end else if (MODE == 1) begin
            evt_d = fall_d;
        end else begin
            evt_d = rise_d | fall_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= '0;
            cnt_q   <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            evt_q   <= '0;
        end else begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            evt_q   <= evt_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;
    assign evt   = evt_q;

`ifdef EDGE_DEBOUNCE_STICKY_EN
    logic [WIDTH-1:0] pend_q, pend_d;

    // A new event wins over a same-cycle clear so no event is lost.
    assign pend_d = (pend_q & ~clr) | evt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pend = pend_q;
`else
    logic [WIDTH-1:0] unused_clr;

    assign unused_clr = clr;
    assign pend       = '0;
`endif

endmodule

// File: tb/tb_edge_debounce.sv
// Scoreboard bench for edge_debounce over four parameter sets.
// Expected pulses are queued with their due cycle when stimulus is driven.
module tb_edge_debounce;

    typedef struct {
        int unsigned cyc;
        logic [3:0]  rise;
        logic [3:0]  fall;
        logic [3:0]  evt;
        logic [3:0]  level;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        sbq[$];

    logic       clr_z = 1'b0;
    logic       in0 = 1'b0, lv0, r0, f0, e0, p0;
    logic       in1 = 1'b0, lv1, r1, f1, e1, p1;
    logic [3:0] in2 = '0, clr2 = '0, lv2, r2, f2, e2, p2;
    logic       in3 = 1'b0, lv3, r3, f3, e3, p3;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    edge_debounce #(.WIDTH(1), .SYNC_STAGES(2), .DEBOUNCE(0), .MODE(2)) u0 (
        .clk(clk), .reset(reset), .in(in0), .clr(clr_z),
        .level(lv0), .rise(r0), .fall(f0), .evt(e0), .pend(p0));

    edge_debounce #(.WIDTH(1), .SYNC_STAGES(2), .DEBOUNCE(3), .MODE(2)) u1 (
        .clk(clk), .reset(reset), .in(in1), .clr(clr_z),
        .level(lv1), .rise(r1), .fall(f1), .evt(e1), .pend(p1));

    edge_debounce #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE(0), .MODE(0)) u2 (
        .clk(clk), .reset(reset), .in(in2), .clr(clr2),
        .level(lv2), .rise(r2), .fall(f2), .evt(e2), .pend(p2));

    edge_debounce #(.WIDTH(1), .SYNC_STAGES(2), .DEBOUNCE(5), .MODE(2)) u3 (
        .clk(clk), .reset(reset), .in(in3), .clr(clr_z),
        .level(lv3), .rise(r3), .fall(f3), .evt(e3), .pend(p3));

    function automatic exp_t mk(int unsigned c, logic [3:0] r, logic [3:0] f,
                                logic [3:0] e, logic [3:0] l);
        exp_t x;
        x.cyc = c; x.rise = r; x.fall = f; x.evt = e; x.level = l;
        return x;
    endfunction

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({lv0, r0, f0, e0, p0, lv1, r1, f1, e1, p1, lv3, r3, f3, e3, p3} !== '0) begin
            errors++;
            $display("FAIL reset_1bit got=%b exp=0",
                     {lv0, r0, f0, e0, p0, lv1, r1, f1, e1, p1, lv3, r3, f3, e3, p3});
        end
        checks++;
        if ({lv2, r2, f2, e2, p2} !== '0) begin
            errors++;
            $display("FAIL reset_4bit got=%h exp=0", {lv2, r2, f2, e2, p2});
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({lv0, r0, e0, lv1, r1, lv2, r2, e2, p2, lv3, r3} !== '0) begin
            errors++;
            $display("FAIL reset_release got=%b exp=0",
                     {lv0, r0, e0, lv1, r1, lv2, r2, e2, p2, lv3, r3});
        end
    endtask

    task automatic test_single();
        exp_t e;
        logic lv = 1'b0;
        sbq.delete();
        for (int k = 0; k < 18; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                in0 = 1'b1;
                sbq.push_back(mk(cyc + 3, 4'h1, 4'h0, 4'h1, 4'h1));
            end
            if (k == 10) begin
                in0 = 1'b0;
                sbq.push_back(mk(cyc + 3, 4'h0, 4'h1, 4'h1, 4'h0));
            end
            @(negedge clk);
            if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
                e = sbq.pop_front();
                lv = e.level[0];
            end else begin
                e = mk(cyc, 4'h0, 4'h0, 4'h0, {3'b0, lv});
            end
            checks++;
            if ({lv0, r0, f0, e0} !== {lv, e.rise[0], e.fall[0], e.evt[0]}) begin
                errors++;
                $display("FAIL single cyc=%0d lrfe got=%b exp=%b", cyc,
                         {lv0, r0, f0, e0}, {lv, e.rise[0], e.fall[0], e.evt[0]});
            end
        end
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL single_missing got=%0d pending exp=0", sbq.size());
        end
    endtask

    task automatic test_debounce();
        exp_t e;
        logic lv = 1'b0;
        sbq.delete();
        for (int k = 0; k < 32; k++) begin
            @(posedge clk); #1;
            if (k == 0) in1 = 1'b1;
            if (k == 3) in1 = 1'b0;
            if (k == 15) begin
                in1 = 1'b1;
                sbq.push_back(mk(cyc + 6, 4'h1, 4'h0, 4'h1, 4'h1));
            end
            if (k == 19) begin
                in1 = 1'b0;
                sbq.push_back(mk(cyc + 6, 4'h0, 4'h1, 4'h1, 4'h0));
            end
            @(negedge clk);
            if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
                e = sbq.pop_front();
                lv = e.level[0];
            end else begin
                e = mk(cyc, 4'h0, 4'h0, 4'h0, {3'b0, lv});
            end
            checks++;
            if ({lv1, r1, f1, e1} !== {lv, e.rise[0], e.fall[0], e.evt[0]}) begin
                errors++;
                $display("FAIL debounce k=%0d lrfe got=%b exp=%b", k,
                         {lv1, r1, f1, e1}, {lv, e.rise[0], e.fall[0], e.evt[0]});
            end
        end
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL debounce_missing got=%0d pending exp=0", sbq.size());
        end
    endtask

    task automatic test_sticky();
        exp_t       e;
        logic [3:0] lv = '0;
        logic [3:0] pm = '0;
        sbq.delete();
        for (int k = 0; k < 22; k++) begin
            @(posedge clk); #1;
            if (k == 0 || k == 10) begin
                in2 = 4'b0100;
                sbq.push_back(mk(cyc + 3, 4'b0100, 4'h0, 4'b0100, 4'b0100));
            end
            if (k == 5 || k == 16) begin
                in2 = 4'b0000;
                sbq.push_back(mk(cyc + 3, 4'h0, 4'b0100, 4'h0, 4'h0));
            end
            if (k == 13 || k == 16) clr2 = 4'b0100;
            if (k == 14 || k == 17) clr2 = 4'b0000;
            @(negedge clk);
            if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
                e = sbq.pop_front();
                lv = e.level;
            end else begin
                e = mk(cyc, 4'h0, 4'h0, 4'h0, lv);
            end
            checks++;
            if ({lv2, r2, f2, e2, p2} !== {lv, e.rise, e.fall, e.evt, pm}) begin
                errors++;
                $display("FAIL sticky k=%0d lrfep got=%h exp=%h", k,
                         {lv2, r2, f2, e2, p2}, {lv, e.rise, e.fall, e.evt, pm});
            end
`ifdef EDGE_DEBOUNCE_STICKY_EN
            pm = (pm & ~clr2) | e.evt;
`endif
        end
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL sticky_missing got=%0d pending exp=0", sbq.size());
        end
    endtask

    task automatic test_multi();
        exp_t       e;
        logic [3:0] lv = '0;
        sbq.delete();
        for (int k = 0; k < 16; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                in2 = 4'b0101;
                sbq.push_back(mk(cyc + 3, 4'b0101, 4'h0, 4'b0101, 4'b0101));
            end
            if (k == 8) begin
                in2 = 4'b0000;
                sbq.push_back(mk(cyc + 3, 4'h0, 4'b0101, 4'h0, 4'h0));
            end
            @(negedge clk);
            if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
                e = sbq.pop_front();
                lv = e.level;
            end else begin
                e = mk(cyc, 4'h0, 4'h0, 4'h0, lv);
            end
            checks++;
            if ({lv2, r2, f2, e2} !== {lv, e.rise, e.fall, e.evt}) begin
                errors++;
                $display("FAIL multi k=%0d lrfe got=%h exp=%h", k,
                         {lv2, r2, f2, e2}, {lv, e.rise, e.fall, e.evt});
            end
        end
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL multi_missing got=%0d pending exp=0", sbq.size());
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        logic lv = 1'b0;
        sbq.delete();
        for (int k = 0; k < 32; k++) begin
            @(posedge clk); #1;
            if (k == 0) in3 = 1'b1;
            if (k == 5) reset = 1'b1;
            if (k == 6) begin
                reset = 1'b0;
                sbq.push_back(mk(cyc + 8, 4'h1, 4'h0, 4'h1, 4'h1));
            end
            if (k == 20) begin
                in3 = 1'b0;
                sbq.push_back(mk(cyc + 8, 4'h0, 4'h1, 4'h1, 4'h0));
            end
            @(negedge clk);
            if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
                e = sbq.pop_front();
                lv = e.level[0];
            end else begin
                e = mk(cyc, 4'h0, 4'h0, 4'h0, {3'b0, lv});
            end
            checks++;
            if ({lv3, r3, f3, e3} !== {lv, e.rise[0], e.fall[0], e.evt[0]}) begin
                errors++;
                $display("FAIL reset_mid k=%0d lrfe got=%b exp=%b", k,
                         {lv3, r3, f3, e3}, {lv, e.rise[0], e.fall[0], e.evt[0]});
            end
        end
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL reset_mid_missing got=%0d pending exp=0", sbq.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_debounce();
        test_sticky();
        test_multi();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
